// File: rtl/conv_pixel_feeder.sv
// Streams a square image from memory in raster order into a convolution datapath and
// tags the datapath results that correspond to full KERNEL_SIZE x KERNEL_SIZE windows.
module conv_pixel_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  parameter int ADDR_WIDTH  = 10,
  parameter int DP_LATENCY  = 1,
  parameter int IDX_WIDTH   = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  output logic signed [DATA_WIDTH-1:0] pixel_input,
  output logic                         write,
  output logic                         result_valid,
  output logic [IDX_WIDTH-1:0]         out_row,
  output logic [IDX_WIDTH-1:0]         out_col,
  output logic                         busy,
  output logic                         done
);

  localparam int NPIX = IMAGE_SIZE * IMAGE_SIZE;
  localparam int CW   = $clog2(DP_LATENCY + 2) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [IDX_WIDTH-1:0]  KM1       = IDX_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_COL  = IDX_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0]         DRAIN_END = CW'(DP_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                          r_state, w_next;
  logic [ADDR_WIDTH-1:0]           r_addr;
  logic                            w_rd, w_last_rd, w_accept;
  logic                            r_rd_d1;
  logic [IDX_WIDTH-1:0]            r_row, r_col;
  logic [IDX_WIDTH-1:0]            r_wr_row, r_wr_col;
  logic [CW-1:0]                   r_dcnt;
  logic                            w_vld0;
  logic [IDX_WIDTH-1:0]            w_orow0, w_ocol0;
  logic [DP_LATENCY:1]             r_vld_pipe;
  logic [DP_LATENCY:1][IDX_WIDTH-1:0] r_row_pipe, r_col_pipe;

  assign w_accept  = (r_state == IDLE) && start;
  assign w_last_rd = w_rd && (r_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = FETCH;
      FETCH: begin
        w_rd = reset && !stall;
        if (w_last_rd) w_next = DRAIN;
      end
      DRAIN: if (r_dcnt == DRAIN_END) w_next = DONE;
      DONE: begin
        done   = reset;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (r_state != IDLE) busy = reset;
  end

  assign mem_rd_en = w_rd;
  assign mem_addr  = r_addr;

  always_ff @(posedge clk) begin
    if (!reset)                  r_addr <= '0;
    else if (w_accept)           r_addr <= '0;
    else if (w_rd && !w_last_rd) r_addr <= r_addr + 1'b1;
  end

  // DRAIN ends once the final write and its DP_LATENCY result delay have both elapsed.
  always_ff @(posedge clk) begin
    if (!reset)                r_dcnt <= '0;
    else if (r_state == DRAIN) r_dcnt <= r_dcnt + 1'b1;
    else                       r_dcnt <= '0;
  end

  // Read data lands one cycle after the strobe; capture it with the coordinates of that pixel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_d1     <= 1'b0;
      write       <= 1'b0;
      pixel_input <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_wr_row    <= '0;
      r_wr_col    <= '0;
    end else begin
      r_rd_d1 <= w_rd;
      write   <= r_rd_d1;
      if (w_accept) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_rd_d1) begin
        pixel_input <= $signed(mem_rd_data);
        r_wr_row    <= r_row;
        r_wr_col    <= r_col;
        if (r_col == LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign w_vld0  = write && (r_wr_row >= KM1) && (r_wr_col >= KM1);
  assign w_orow0 = r_wr_row - KM1;
  assign w_ocol0 = r_wr_col - KM1;

  // Result tag pipeline runs freely; coordinate stages only load with a valid so they hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld_pipe <= '0;
      r_row_pipe <= '0;
      r_col_pipe <= '0;
    end else begin
      r_vld_pipe[1] <= w_vld0;
      if (w_vld0) begin
        r_row_pipe[1] <= w_orow0;
        r_col_pipe[1] <= w_ocol0;
      end
      for (int s = 2; s <= DP_LATENCY; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) begin
          r_row_pipe[s] <= r_row_pipe[s-1];
          r_col_pipe[s] <= r_col_pipe[s-1];
        end
      end
    end
  end

  assign result_valid = r_vld_pipe[DP_LATENCY];
  assign out_row      = r_row_pipe[DP_LATENCY];
  assign out_col      = r_col_pipe[DP_LATENCY];

endmodule

// File: tb/tb_conv_pixel_feeder.sv
// Drives two feeders (datapath latency 1 and 3) with shared random stimulus and checks
// each against a pass-level model built from raster-order read/write/result timing.
module tb_conv_pixel_feeder;
  localparam int DW = 16, K = 5, IS = 28, AW = 10, IW = 5;
  localparam int NPIX = IS * IS, OS = IS - K + 1, NRES = OS * OS;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stall = 1'b0;
  logic [1:0] rd_en, wr, rv, busy, done;
  logic [1:0][AW-1:0] addr;
  logic [1:0][DW-1:0] mdata, pix;
  logic [1:0][IW-1:0] orow, ocol;

  conv_pixel_feeder #(.DP_LATENCY(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .mem_rd_en(rd_en[0]), .mem_addr(addr[0]), .mem_rd_data(mdata[0]),
    .pixel_input(pix[0]), .write(wr[0]), .result_valid(rv[0]),
    .out_row(orow[0]), .out_col(ocol[0]), .busy(busy[0]), .done(done[0]));

  conv_pixel_feeder #(.DP_LATENCY(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .mem_rd_en(rd_en[1]), .mem_addr(addr[1]), .mem_rd_data(mdata[1]),
    .pixel_input(pix[1]), .write(wr[1]), .result_valid(rv[1]),
    .out_row(orow[1]), .out_col(ocol[1]), .busy(busy[1]), .done(done[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory word k holds k; unread cycles return noise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      mdata[d] <= rd_en[d] ? DW'(addr[d]) : DW'($urandom);
  end

  int checks = 0, fails = 0;
  int DPL[2] = '{1, 3};
  int nrd[2], nwr[2], nval[2], ndone[2], done_cyc[2];
  bit active[2], zchk[2];
  int rd_cyc[2][NPIX];
  int wr_cyc[2][NPIX];
  logic [2*IW-1:0] lrc[2];

  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", tag, d, cyc, got, exp);
    end
  endtask

  task automatic clear_pass(input int d);
    nrd[d] = 0; nwr[d] = 0; nval[d] = 0; done_cyc[d] = -1;
  endtask

  task automatic mon(input int d, input logic rd, input logic [AW-1:0] a, input logic w,
                     input logic [DW-1:0] p, input logic v, input logic [IW-1:0] r_, input logic [IW-1:0] c_,
                     input logic b, input logic dn);
    int j, k;
    logic ew, ev, fetch;
    logic [2*IW-1:0] erc;
    if (zchk[d]) begin
      chk("rst_ctl", d, {rd, w, v, b, dn}, 0);
      chk("rst_addr", d, a, 0);
      chk("rst_pix", d, p, 0);
      chk("rst_rc", d, {r_, c_}, 0);
      zchk[d] = 0;
    end
    if (!reset) begin
      active[d] = 0; zchk[d] = 1; clear_pass(d);
      return;
    end
    chk("busy", d, b, active[d]);
    chk("done", d, dn, done_cyc[d] >= 0 && cyc == done_cyc[d]);
    fetch = active[d] && nrd[d] < NPIX;
    chk("rd_en", d, rd, fetch && !stall);
    if (rd && fetch) begin
      chk("addr", d, a, nrd[d]);
      rd_cyc[d][nrd[d]] = cyc;
      nrd[d]++;
    end
    ew = nwr[d] < nrd[d] && rd_cyc[d][nwr[d]] + 2 == cyc;
    chk("write", d, w, ew);
    if (w && ew) begin
      chk("pixel", d, p, nwr[d]);
      wr_cyc[d][nwr[d]] = cyc;
      nwr[d]++;
      if (nwr[d] == NPIX) done_cyc[d] = cyc + DPL[d] + 1;
    end
    j = nval[d];
    k = (j / OS + K - 1) * IS + (j % OS) + K - 1;
    ev = j < NRES && k < nwr[d] && wr_cyc[d][k] + DPL[d] == cyc;
    chk("res_valid", d, v, ev);
    if (v && ev) begin
      erc = {IW'(j / OS), IW'(j % OS)};
      chk("out_rc", d, {r_, c_}, erc);
      lrc[d] = erc;
      nval[d]++;
    end else if (!v && nval[d] > 0) begin
      chk("rc_hold", d, {r_, c_}, lrc[d]);
    end
    if (active[d] && done_cyc[d] >= 0 && cyc == done_cyc[d]) begin
      chk("n_writes", d, nwr[d], NPIX);
      chk("n_valid", d, nval[d], NRES);
      ndone[d]++;
      active[d] = 0;
    end else if (!active[d] && start) begin
      active[d] = 1;
      clear_pass(d);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      mon(d, rd_en[d], addr[d], wr[d], pix[d], rv[d], orow[d], ocol[d], busy[d], done[d]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000 && (active[0] || active[1]); i++) step();
    chk("timeout", 0, active[0] || active[1], 0);
  endtask

  initial begin
    ndone = '{0, 0};
    for (int d = 0; d < 2; d++) begin
      clear_pass(d); active[d] = 0; zchk[d] = 0; lrc[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) step();

    // Pass 1: no stall, start re-pulsed mid-fetch and in the done cycle.
    pulse_start();
    repeat (50) step();
    pulse_start();
    for (int i = 0; i < 3000 && !done[0]; i++) step();
    chk("done_seen", 0, done[0], 1);
    pulse_start();
    wait_idle();
    repeat (4) step();

    // Pass 2: forced stall on fetch cycles 10-14 plus random stalls.
    pulse_start();
    for (int i = 0; i < 5000 && nrd[0] < NPIX; i++) begin
      stall = (i >= 10 && i <= 14) || (i > 30 && $urandom_range(0, 5) == 0);
      step();
    end
    stall = 1'b0;
    wait_idle();
    repeat (3) step();

    // Pass 3: aborted by a one-cycle reset after write #300.
    pulse_start();
    for (int i = 0; i < 5000 && nwr[0] < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      step();
    end
    stall = 1'b0;
    reset = 1'b0; step(); reset = 1'b1;
    repeat (6) step();

    // Pass 4: full pass after the abort, random stalls.
    pulse_start();
    for (int i = 0; i < 5000 && nrd[0] < NPIX; i++) begin
      stall = ($urandom_range(0, 2) == 0);
      step();
    end
    stall = 1'b0;
    wait_idle();
    repeat (5) step();

    chk("passes", 0, ndone[0], 3);
    chk("passes", 1, ndone[1], 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/conv_pixel_feeder.md
CONV_PIXEL_FEEDER -- requirements
Module: conv_pixel_feeder

Interface
REQ-001 Parameter DATA_WIDTH, default 16, is the pixel word width.
REQ-002 Parameter KERNEL_SIZE, default 5, is the convolution window edge.
REQ-003 Parameter IMAGE_SIZE, default 28, is the square image edge.
REQ-004 Parameter ADDR_WIDTH, default 10, is the image memory address width, with 2**ADDR_WIDTH >= IMAGE_SIZE**2.
REQ-005 Parameter DP_LATENCY, default 1, is the cycles from a write into the datapath to its add_result for that pixel.
REQ-006 Parameter IDX_WIDTH, default 5, is the row/col index width, with 2**IDX_WIDTH >= IMAGE_SIZE.
REQ-007 Port clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-008 Port reset, input, 1 bit: reset is synchronous and active-low.
REQ-009 Port start, input, 1 bit, requests one full image pass.
REQ-010 Port stall, input, 1 bit, is downstream backpressure that pauses new reads.
REQ-011 Port mem_rd_en, output, 1 bit, is the image memory read strobe.
REQ-012 Port mem_addr, output, ADDR_WIDTH bits, is the read address in raster order, row*IMAGE_SIZE+col.
REQ-013 Port mem_rd_data, input, DATA_WIDTH bits, is read data valid exactly one cycle after mem_rd_en.
REQ-014 Port pixel_input, output, DATA_WIDTH signed bits, is the registered pixel to the datapath.
REQ-015 Port write, output, 1 bit, is a one-cycle strobe marking pixel_input valid for the datapath.
REQ-016 Port result_valid, output, 1 bit, marks the datapath add_result as a full, valid window.
REQ-017 Port out_row, output, IDX_WIDTH bits, is the output-map row of the valid result.
REQ-018 Port out_col, output, IDX_WIDTH bits, is the output-map column of the valid result.
REQ-019 Port busy, output, 1 bit, is high in any state other than IDLE.
REQ-020 Port done, output, 1 bit, is a one-cycle pulse at the end of a pass.

Function
REQ-021 The FSM SHALL have four states: IDLE, FETCH, DRAIN and DONE.
REQ-022 IDLE SHALL move to FETCH on start=1, with the address counter cleared to 0.
REQ-023 In FETCH with stall=0, mem_rd_en SHALL be 1 and mem_addr SHALL increment by 1 per cycle.
REQ-024 In FETCH with stall=1, mem_rd_en SHALL be 0 and mem_addr SHALL hold.
REQ-025 A read issued in cycle t SHALL produce pixel_input=mem_rd_data and write=1 in cycle t+2, independent of the stall value in t+1.
REQ-026 write SHALL be 1 exactly once per issued read, so there are exactly IMAGE_SIZE**2 write pulses per pass.
REQ-027 Row and column counters SHALL follow each write: col wraps IMAGE_SIZE-1 -> 0 and increments row; row does not wrap within a pass.
REQ-028 FETCH SHALL move to DRAIN after the read at address IMAGE_SIZE**2-1 is issued.
REQ-029 DRAIN SHALL last until the final write plus DP_LATENCY cycles have elapsed, then move to DONE.
REQ-030 DONE SHALL assert done=1 for one cycle, then move to IDLE.
REQ-031 A write of pixel (r,c) with r>=KERNEL_SIZE-1 and c>=KERNEL_SIZE-1 SHALL raise result_valid exactly DP_LATENCY cycles later.
REQ-032 That result_valid SHALL carry out_row=r-(KERNEL_SIZE-1) and out_col=c-(KERNEL_SIZE-1).
REQ-033 The result_valid and out_row/out_col delay SHALL be a DP_LATENCY-deep shift pipeline that advances every cycle, independent of stall.
REQ-034 A pass SHALL produce exactly (IMAGE_SIZE-KERNEL_SIZE+1)**2 result_valid pulses, which is 576 at the default parameters.
REQ-035 start SHALL be ignored while busy=1.
REQ-036 start asserted in the same cycle as done=1 SHALL be ignored; a new pass needs start in IDLE.
REQ-037 When result_valid=0, out_row and out_col SHALL hold their last values.

Reset
REQ-038 On a clk edge with reset=0, the FSM SHALL go to IDLE and all counters and delay pipelines SHALL clear.
REQ-039 Under reset, every output SHALL be 0: mem_rd_en, mem_addr, pixel_input, write, result_valid, out_row, out_col, busy and done.
REQ-040 Reset mid-pass SHALL abort the pass with no done pulse, and SHALL drop any in-flight read or pending result_valid.
REQ-041 After reset is released, the block SHALL stay in IDLE until start=1.

Verification
REQ-042 Memory word k holds k; pulse start with stall=0 -> first write at cycle 3 after start with pixel_input=0; 784 writes carrying values 0..783 in order; done pulses once; busy is high from the cycle after start through done.
REQ-043 Default parameters with DP_LATENCY=1 -> 576 result_valid pulses; the first comes 1 cycle after the write of pixel (4,4) with out_row=0, out_col=0; the last carries out_row=23, out_col=23.
REQ-044 stall=1 for cycles 10-14 of FETCH -> no mem_rd_en in those cycles; the write sequence still has no gaps in data order and no duplicates; totals stay 784 writes and 576 valids.
REQ-045 start re-pulsed during FETCH and again in the done cycle -> both ignored; exactly one pass and one done pulse.
REQ-046 reset=0 for one cycle after write #300 -> next cycle all outputs 0 and busy=0; no done pulse; a following start gives a full 784-write pass from address 0.
REQ-047 DP_LATENCY=3 -> each result_valid lags its qualifying write by 3 cycles; done follows the final write by 4 cycles.
